digest_scan_out: RTL and testbench
==================================

// Module: digest_scan_out
// PURPOSE
//  Egress counterpart to the 136-bit scan input path of the SHA3-256 core.
//  - Watches the core's complete flag and captures its 256-bit digest on each 0->1 edge.
//  - Streams the captured digest out in OUT_W-bit beats over a valid/ready handshake.
//  - Sits between the hash core (digest, complete) and the off-chip or test readout logic.
// PARAMETERS
//  DIGEST_W  256  captured digest width; must be a multiple of OUT_W
//  OUT_W     32   beat width on scan_out
//  BEATS     DIGEST_W/OUT_W (8)  derived localparam, beats per digest
// PORTS
//  clk          in   1         single clock, rising edge
//  reset_n      in   1         asynchronous, active-low reset
//  digest       in   DIGEST_W  core digest (state bits [255:0])
//  complete     in   1         core rounds-completed flag (level)
//  scan_ready   in   1         sink accepts the current beat
//  overrun_clr  in   1         synchronous clear of the sticky overrun flag
//  scan_out     out  OUT_W     current beat data
//  scan_valid   out  1         scan_out holds a valid beat
//  scan_last    out  1         current beat is beat BEATS-1
//  busy         out  1         a digest is captured and not yet fully sent
//  overrun      out  1         sticky: a digest was dropped
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - Outputs: scan_out=0, scan_valid=0, scan_last=0, busy=0, overrun=0.
//  - State: FSM=IDLE, beat_cnt=0, shadow=0, complete_q=1.
//  - complete_q resets to 1 because the core holds complete=1 through its own reset.
//    A complete that is already high at reset release is not a capture edge.
//  Edge detect: cap_evt = complete & ~complete_q; complete_q <= complete every cycle.
//  FSM IDLE:
//  - On cap_evt: shadow <= digest, beat_cnt <= 0, go to SEND.
//  - The first beat is valid on the cycle after the edge (latency 1).
//  FSM SEND:
//  - scan_valid=1; scan_out = shadow[beat_cnt*OUT_W +: OUT_W]. LSB beat first, so beat 0 = digest[31:0].
//  - scan_last = (beat_cnt==BEATS-1). busy=1 in SEND only.
//  - A beat transfers when scan_valid & scan_ready. After a transfer, beat_cnt increments.
//  - While scan_ready=0: scan_out, scan_last and beat_cnt stay stable; valid is never withdrawn.
//  - When the last beat transfers:
//    - with no cap_evt: go to IDLE and deassert scan_valid on the next cycle.
//    - with cap_evt in the same cycle: capture the new digest, beat_cnt <= 0, stay in SEND.
//      Back-to-back, no bubble, no overrun.
//  - cap_evt in SEND on any other cycle:
//    - the new digest is dropped and overrun <= 1;
//    - the transfer in progress continues unchanged.
//  - overrun stays set until overrun_clr=1. If set and clear happen in the same cycle, set wins.
//  - shadow is written only on an accepted capture. The core changing digest mid-send has no effect.
//  Reset mid-SEND: immediate return to reset values. The partial digest is discarded and no scan_last is produced.
//  Widths: beat_cnt is clog2(BEATS) bits. It never wraps past BEATS-1 and returns to 0 only on capture or reset.
// TESTING
//  1 Reset release with complete=1, held for 20 cycles -> scan_valid stays 0, busy=0, overrun=0.
//  2 complete 0->1 with digest=256'h0011..EEFF, scan_ready=1 -> 8 beats on consecutive cycles starting 1 cycle after the edge.
//    Beat0=digest[31:0], beat7=digest[255:224], scan_last only on beat7, then scan_valid=0.
//  3 scan_ready toggling pseudo-randomly (about 50%) -> sink reassembles a word equal to the captured digest.
//    scan_out is stable whenever valid&~ready; exactly 8 transfers.
//  4 Second complete edge at beat 3 with a different digest -> overrun=1; stream continues with the first digest.
//    overrun_clr pulse -> overrun=0; overrun_clr and a new drop in the same cycle -> overrun=1.
//  5 Second edge in the same cycle as the beat-7 transfer -> next cycle beat0 of the new digest, overrun=0.
//  6 reset_n low asynchronously mid-beat 4 -> outputs 0 immediately. After release, a new edge streams a full fresh digest from beat0.

Source files
------------

// File: rtl/digest_scan_out.sv
// Captures the hash core's digest on each rising edge of complete and streams it
// out LSB-beat-first over a valid/ready handshake, flagging dropped digests.
module digest_scan_out #(
  parameter int DIGEST_W = 256,
  parameter int OUT_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                complete,
  input  logic                scan_ready,
  input  logic                overrun_clr,
  output logic [OUT_W-1:0]    scan_out,
  output logic                scan_valid,
  output logic                scan_last,
  output logic                busy,
  output logic                overrun
);

  localparam int BEATS = DIGEST_W / OUT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    beat_cnt;
  logic [CNT_W-1:0]    nxt_cnt;
  logic [DIGEST_W-1:0] shadow;
  logic                complete_q;
  logic                cap_evt;
  logic                xfer;
  logic                last_xfer;
  logic                accept;
  logic                drop;

  function automatic logic [OUT_W-1:0] beat_of(input logic [DIGEST_W-1:0] v,
                                               input logic [CNT_W-1:0]    idx);
    return v[idx*OUT_W +: OUT_W];
  endfunction

  // A capture is only taken when idle or when it coincides with the final
  // beat's transfer; any other edge during a send is a dropped digest.
  always_comb begin
    cap_evt   = complete & ~complete_q;
    xfer      = (state == SEND) & scan_ready;
    last_xfer = xfer & (beat_cnt == LAST_CNT);
    accept    = cap_evt & ((state == IDLE) | last_xfer);
    drop      = cap_evt & (state == SEND) & ~last_xfer;
    nxt_cnt   = beat_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      shadow     <= '0;
      complete_q <= 1'b1;
      scan_out   <= '0;
      scan_valid <= 1'b0;
      scan_last  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      complete_q <= complete;

      if (drop)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;

      // Outputs are registered, so each branch preloads the beat to be shown next.
      if (accept) begin
        shadow     <= digest;
        beat_cnt   <= '0;
        state      <= SEND;
        scan_valid <= 1'b1;
        busy       <= 1'b1;
        scan_out   <= digest[OUT_W-1:0];
        scan_last  <= 1'(BEATS == 1);
      end else if (last_xfer) begin
        state      <= IDLE;
        scan_valid <= 1'b0;
        busy       <= 1'b0;
        scan_last  <= 1'b0;
        scan_out   <= '0;
      end else if (xfer) begin
        beat_cnt  <= nxt_cnt;
        scan_out  <= beat_of(shadow, nxt_cnt);
        scan_last <= (nxt_cnt == LAST_CNT);
      end
    end
  end

endmodule

// File: tb/tb_digest_scan_out.sv
// Scoreboard bench for digest_scan_out: stimulus pushes expected beats, a
// negedge monitor pops and compares every accepted beat.
module tb_digest_scan_out;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] digest;
  logic         complete;
  logic         scan_ready;
  logic         overrun_clr;
  logic [31:0]  scan_out;
  logic         scan_valid;
  logic         scan_last;
  logic         busy;
  logic         overrun;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    n_xfer = 0;

  localparam logic [255:0] D1  = 256'h00112233445566778899AABBCCDDEEFF00112233445566778899AABBCCDDEEFF;
  localparam logic [255:0] D2  = 256'hDEADBEEF_01234567_89ABCDEF_FEDCBA98_76543210_CAFEF00D_0BADC0DE_A5A55A5A;
  localparam logic [255:0] D3  = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
  localparam logic [255:0] D4  = 256'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_00000000;
  localparam logic [255:0] D5  = 256'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0_13579BDF_2468ACE0_FACEB00C_C001D00D;
  localparam logic [255:0] D6  = 256'h5555AAAA_AAAA5555_0000FFFF_FFFF0000_12121212_34343434_56565656_78787878;
  localparam logic [255:0] D7  = 256'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3_E0E1E2E3_F0F1F2F3_01020304_05060708;
  localparam logic [255:0] D8  = 256'h80000001_40000002_20000004_10000008_08000010_04000020_02000040_01000080;
  localparam logic [255:0] D9  = 256'h99999999_88888888_77777777_66666666_55555555_44444444_33333333_22222222;
  localparam logic [255:0] D10 = 256'h31415926_53589793_23846264_33832795_02884197_16939937_51058209_74944592;

  digest_scan_out #(.DIGEST_W(256), .OUT_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .digest      (digest),
    .complete    (complete),
    .scan_ready  (scan_ready),
    .overrun_clr (overrun_clr),
    .scan_out    (scan_out),
    .scan_valid  (scan_valid),
    .scan_last   (scan_last),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_digest(input logic [255:0] d);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.data = d[i*32 +: 32];
      b.last = (i == 7);
      exp_q.push_back(b);
    end
  endtask

  // Raise complete from a known-low level so the next posedge sees an edge.
  task automatic new_edge(input logic [255:0] d, input bit expect_accept);
    complete = 1'b0;
    step();
    digest   = d;
    complete = 1'b1;
    if (expect_accept) push_digest(d);
  endtask

  // Monitor: compare each accepted beat and check hold stability under backpressure.
  initial begin : monitor
    beat_t       b;
    logic        hold = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 64'(scan_valid), 64'd1);
          check("hold_data", 64'(scan_out), 64'(hold_data));
          check("hold_last", 64'(scan_last), 64'(hold_last));
        end
        hold      = scan_valid & ~scan_ready;
        hold_data = scan_out;
        hold_last = scan_last;
        if (scan_valid && scan_ready) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got %0h expected no beat", scan_out);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", 64'(scan_out), 64'(b.data));
            check("beat_last", 64'(scan_last), 64'(b.last));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [255:0] d;
    int           x0;
    bit           bad;
    int           guard;

    reset_n     = 1'b0;
    complete    = 1'b1;
    digest      = '0;
    scan_ready  = 1'b0;
    overrun_clr = 1'b0;
    #3;
    check("rst_scan_out", 64'(scan_out), 64'd0);
    check("rst_valid", 64'(scan_valid), 64'd0);
    check("rst_last", 64'(scan_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    // 1: complete held high across reset release is not an edge
    #9 reset_n = 1'b1;
    digest = D1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (scan_valid || busy || overrun) bad = 1'b1;
    end
    check("t1_no_capture", 64'(bad), 64'd0);

    // 2: basic stream, latency 1, 8 consecutive beats
    scan_ready = 1'b1;
    new_edge(D1, 1'b1);
    step();
    d = D1;
    check("t2_latency_valid", 64'(scan_valid), 64'd1);
    check("t2_beat0", 64'(scan_out), 64'(d[31:0]));
    check("t2_busy", 64'(busy), 64'd1);
    complete = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("t2_valid_after", 64'(scan_valid), 64'd0);
    check("t2_busy_after", 64'(busy), 64'd0);
    check("t2_q_drained", 64'(exp_q.size()), 64'd0);

    // 3: random backpressure
    x0 = n_xfer;
    new_edge(D2, 1'b1);
    guard = 0;
    step();
    complete = 1'b0;
    while ((scan_valid || busy) && guard < 300) begin
      scan_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    check("t3_finished", 64'(guard < 300), 64'd1);
    check("t3_xfer_count", 64'(n_xfer - x0), 64'd8);
    scan_ready = 1'b1;

    // 4: drop at beat 3, clear, then set+clear in same cycle
    new_edge(D3, 1'b1);
    step();
    complete = 1'b0;
    step();
    step();
    step();
    digest   = D4;
    complete = 1'b1;
    step();
    check("t4_overrun_set", 64'(overrun), 64'd1);
    digest = D6;
    for (int i = 0; i < 4; i++) step();
    check("t4_done", 64'(scan_valid), 64'd0);
    check("t4_overrun_sticky", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("t4_overrun_clr", 64'(overrun), 64'd0);
    new_edge(D5, 1'b1);
    step();
    complete = 1'b0;
    step();
    digest      = D6;
    complete    = 1'b1;
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("t4_set_wins", 64'(overrun), 64'd1);
    for (int i = 0; i < 6; i++) step();
    check("t4b_done", 64'(scan_valid), 64'd0);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("t4b_overrun_clr", 64'(overrun), 64'd0);

    // 5: new edge coincides with the beat-7 transfer
    new_edge(D7, 1'b1);
    step();
    complete = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("t5_on_last", 64'(scan_last), 64'd1);
    digest   = D8;
    complete = 1'b1;
    push_digest(D8);
    step();
    d = D8;
    check("t5_b2b_valid", 64'(scan_valid), 64'd1);
    check("t5_b2b_beat0", 64'(scan_out), 64'(d[31:0]));
    check("t5_no_overrun", 64'(overrun), 64'd0);
    complete = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("t5_done", 64'(scan_valid), 64'd0);
    check("t5_q_drained", 64'(exp_q.size()), 64'd0);

    // 6: async reset while beat 4 is presented
    new_edge(D9, 1'b1);
    step();
    complete = 1'b0;
    for (int i = 0; i < 4; i++) step();
    d = D9;
    check("t6_at_beat4", 64'(scan_out), 64'(d[159:128]));
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_scan_out", 64'(scan_out), 64'd0);
    check("t6_rst_valid", 64'(scan_valid), 64'd0);
    check("t6_rst_last", 64'(scan_last), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    step();
    #3 reset_n = 1'b1;
    step();
    new_edge(D10, 1'b1);
    step();
    d = D10;
    check("t6_fresh_beat0", 64'(scan_out), 64'(d[31:0]));
    complete = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("t6_done", 64'(scan_valid), 64'd0);
    check("t6_q_drained", 64'(exp_q.size()), 64'd0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
